// File: rtl/tx_queue_sched.sv
// tx_queue_sched: frame-granular TX scheduler for the net, req and mem queues.
//   Arbitration takes 1 cycle; the grant is held until the eof word is popped, then GAP and IDLE follow.
//   Reads are gated by tx_ready and by the granted queue's empty flag; tx_pause throttles netq producers.
// Priority is fixed (net > req > mem). An aging counter forces mem to win after AGE_MAX lost arbitrations.
// Ports: clk/reset (async active-high), per-queue empty/eof flags in, netq_space in, tx_ready in;
//        per-queue read strobes, sel (00 idle, 01 req, 10 mem, 11 net), tx_pause, underrun and abort out.
// Optional macro SCHED_WATCHDOG_EN: aborts a grant after MAX_FRAME words without eof.
//   Without the macro, abort is tied to 0.
module tx_queue_sched #(
    parameter int AGE_MAX   = 4,
    parameter int PAUSE_ON  = 5,
    parameter int PAUSE_OFF = 8,
    parameter int MAX_FRAME = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       memq_empty,
    input  logic       netq_empty,
    input  logic       reqq_empty,
    input  logic       memq_eof,
    input  logic       netq_eof,
    input  logic       reqq_eof,
    input  logic [3:0] netq_space,
    input  logic       tx_ready,
    output logic       memq_read,
    output logic       netq_read,
    output logic       reqq_read,
    output logic [1:0] sel,
    output logic       tx_pause,
    output logic       underrun,
    output logic       abort
);

    typedef enum logic [2:0] {IDLE, G_NET, G_REQ, G_MEM, GAP} state_t;

    localparam logic [3:0] AGE_LIM   = 4'(AGE_MAX);
    localparam logic [3:0] PAUSE_SET = 4'(PAUSE_ON);
    localparam logic [3:0] PAUSE_CLR = 4'(PAUSE_OFF);

    state_t     state, state_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] mem_age, mem_age_nxt;
    logic       in_grant, cur_empty, cur_eof, rd, wd_trip;
    logic       was_empty;  // granted queue was already empty last cycle

`ifdef SCHED_WATCHDOG_EN
    localparam logic [6:0] MAX_CNT = 7'(MAX_FRAME);
    logic [6:0] word_cnt;

    // Counter only runs inside a grant, so leaving the grant clears it for the next entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (!in_grant) begin
            word_cnt <= '0;
        end else if (rd) begin
            word_cnt <= word_cnt + 7'd1;
        end
    end

    assign wd_trip = in_grant && (word_cnt == MAX_CNT);
`else
    assign wd_trip = 1'b0;
`endif

    // Head-of-queue view of whichever queue currently holds the grant.
    always_comb begin
        in_grant  = 1'b0;
        cur_empty = 1'b1;
        cur_eof   = 1'b0;
        case (state)
            G_NET: begin in_grant = 1'b1; cur_empty = netq_empty; cur_eof = netq_eof; end
            G_REQ: begin in_grant = 1'b1; cur_empty = reqq_empty; cur_eof = reqq_eof; end
            G_MEM: begin in_grant = 1'b1; cur_empty = memq_empty; cur_eof = memq_eof; end
            default: ;
        endcase
    end

    // The watchdog cycle suppresses the read so the remainder is re-arbitrated as a new frame.
    assign rd        = in_grant && tx_ready && !cur_empty && !wd_trip;
    assign netq_read = rd && (state == G_NET);
    assign reqq_read = rd && (state == G_REQ);
    assign memq_read = rd && (state == G_MEM);
    assign underrun  = in_grant && cur_empty && !was_empty;
    assign abort     = wd_trip;

    always_comb begin
        state_nxt   = state;
        mem_age_nxt = mem_age;
        case (state)
            IDLE: begin
                if (!memq_empty && (mem_age >= AGE_LIM)) state_nxt = G_MEM;
                else if (!netq_empty)                    state_nxt = G_NET;
                else if (!reqq_empty)                    state_nxt = G_REQ;
                else if (!memq_empty)                    state_nxt = G_MEM;
                // Age only moves when an arbitration actually resolves.
                if (state_nxt == G_MEM) begin
                    mem_age_nxt = 4'd0;
                end else if (state_nxt != IDLE && !memq_empty && mem_age != 4'd15) begin
                    mem_age_nxt = mem_age + 4'd1;
                end
            end
            G_NET, G_REQ, G_MEM: begin
                if (wd_trip || (rd && cur_eof)) state_nxt = GAP;
            end
            default: state_nxt = IDLE;  // GAP is always a single cycle
        endcase
    end

    always_comb begin
        sel_nxt = 2'b00;
        case (state_nxt)
            G_NET:   sel_nxt = 2'b11;
            G_REQ:   sel_nxt = 2'b01;
            G_MEM:   sel_nxt = 2'b10;
            default: sel_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 2'b00;
            mem_age   <= 4'd0;
            was_empty <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            mem_age   <= mem_age_nxt;
            was_empty <= in_grant && cur_empty;
        end
    end

    // Hysteresis: between the two thresholds the previous value is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_pause <= 1'b0;
        end else if (netq_space < PAUSE_SET) begin
            tx_pause <= 1'b1;
        end else if (netq_space >= PAUSE_CLR) begin
            tx_pause <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_queue_sched.sv
module tb_tx_queue_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       memq_empty, netq_empty, reqq_empty;
    logic       memq_eof, netq_eof, reqq_eof;
    logic [3:0] netq_space;
    logic       tx_ready;
    logic       memq_read, netq_read, reqq_read;
    logic [1:0] sel;
    logic       tx_pause, underrun, abort;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SCHED_WATCHDOG_EN
    localparam int TB_MAX_FRAME = 8;
`else
    localparam int TB_MAX_FRAME = 64;
`endif

    tx_queue_sched #(
        .AGE_MAX  (4),
        .PAUSE_ON (5),
        .PAUSE_OFF(8),
        .MAX_FRAME(TB_MAX_FRAME)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memq_empty(memq_empty),
        .netq_empty(netq_empty),
        .reqq_empty(reqq_empty),
        .memq_eof  (memq_eof),
        .netq_eof  (netq_eof),
        .reqq_eof  (reqq_eof),
        .netq_space(netq_space),
        .tx_ready  (tx_ready),
        .memq_read (memq_read),
        .netq_read (netq_read),
        .reqq_read (reqq_read),
        .sel       (sel),
        .tx_pause  (tx_pause),
        .underrun  (underrun),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        memq_empty = 1'b1; netq_empty = 1'b1; reqq_empty = 1'b1;
        memq_eof   = 1'b0; netq_eof   = 1'b0; reqq_eof   = 1'b0;
        netq_space = 4'd15;
        tx_ready   = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({sel, memq_read, netq_read, reqq_read, tx_pause, underrun, abort} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {sel, memq_read, netq_read, reqq_read, tx_pause, underrun, abort});
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({sel, memq_read, netq_read, reqq_read, underrun, abort} !== 7'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b required 0000000",
                     {sel, memq_read, netq_read, reqq_read, underrun, abort});
        end
    endtask

    // net/req refill each other's grants so they alternate; mem always has frames and must age in.
    task automatic test_priority_aging();
        logic [1:0] exp_g [6];
        logic [1:0] prev_sel, cur_sel;
        logic       net_avail, req_avail, s_net, s_req, s_mem;
        int         net_pos, req_pos, mem_pos, ng, nrd, stray;
        exp_g[0] = 2'b11; exp_g[1] = 2'b01; exp_g[2] = 2'b11;
        exp_g[3] = 2'b01; exp_g[4] = 2'b10; exp_g[5] = 2'b11;
        prev_sel = 2'b00; net_avail = 1'b1; req_avail = 1'b1;
        s_net = 1'b0; s_req = 1'b0; s_mem = 1'b0;
        net_pos = 0; req_pos = 0; mem_pos = 0; ng = 0; nrd = 0; stray = 0;
        do_reset();
        for (int c = 0; c < 80 && ng < 6; c++) begin
            @(posedge clk); #1;
            if (s_net) begin
                if (net_pos == 2) begin net_pos = 0; net_avail = 1'b0; end
                else net_pos++;
            end
            if (s_req) begin
                if (req_pos == 2) begin req_pos = 0; req_avail = 1'b0; end
                else req_pos++;
            end
            if (s_mem) mem_pos = (mem_pos == 2) ? 0 : mem_pos + 1;
            if (prev_sel == 2'b01) net_avail = 1'b1;
            if (prev_sel == 2'b11) req_avail = 1'b1;
            netq_empty = !net_avail; reqq_empty = !req_avail; memq_empty = 1'b0;
            netq_eof = (net_pos == 2); reqq_eof = (req_pos == 2); memq_eof = (mem_pos == 2);
            @(negedge clk);
            cur_sel = sel;
            s_net = netq_read; s_req = reqq_read; s_mem = memq_read;
            if (cur_sel != 2'b00 && prev_sel == 2'b00) begin
                n_tests++;
                if (cur_sel !== exp_g[ng]) begin
                    n_fail++;
                    $display("FAIL grant_order_%0d: sel=%b required %b", ng, cur_sel, exp_g[ng]);
                end
                ng++;
                nrd = 0;
            end
            if ((cur_sel == 2'b11 && s_net) || (cur_sel == 2'b01 && s_req) || (cur_sel == 2'b10 && s_mem))
                nrd++;
            if ((s_net && cur_sel != 2'b11) || (s_req && cur_sel != 2'b01) || (s_mem && cur_sel != 2'b10))
                stray++;
            if (cur_sel == 2'b00 && prev_sel != 2'b00) begin
                n_tests++;
                if (nrd !== 3) begin
                    n_fail++;
                    $display("FAIL frame_len_%0d: reads=%0d required 3", ng - 1, nrd);
                end
            end
            prev_sel = cur_sel;
        end
        n_tests++;
        if (ng !== 6) begin
            n_fail++;
            $display("FAIL grant_timeout: grants=%0d required 6", ng);
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL stray_reads: count=%0d required 0", stray);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        @(posedge clk); #1 netq_empty = 1'b0; netq_eof = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({sel, netq_read} !== 3'b000) begin
            n_fail++;
            $display("FAIL sw_cycle0: sel,read=%b required 000", {sel, netq_read});
        end
        @(negedge clk);
        n_tests++;
        if ({sel, netq_read} !== 3'b111) begin
            n_fail++;
            $display("FAIL sw_cycle1: sel,read=%b required 111", {sel, netq_read});
        end
        @(posedge clk); #1 netq_empty = 1'b1; netq_eof = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({sel, netq_read} !== 3'b000) begin
            n_fail++;
            $display("FAIL sw_gap: sel,read=%b required 000", {sel, netq_read});
        end
        @(negedge clk);
        n_tests++;
        if ({sel, netq_read} !== 3'b000) begin
            n_fail++;
            $display("FAIL sw_idle: sel,read=%b required 000", {sel, netq_read});
        end
    endtask

    task automatic test_pause();
        logic [3:0] sp [6];
        logic       ex [6];
        sp[0] = 4'd8; sp[1] = 4'd6; sp[2] = 4'd4; sp[3] = 4'd5; sp[4] = 4'd7; sp[5] = 4'd8;
        ex[0] = 1'b0; ex[1] = 1'b0; ex[2] = 1'b1; ex[3] = 1'b1; ex[4] = 1'b1; ex[5] = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 netq_space = sp[i];
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (tx_pause !== ex[i]) begin
                n_fail++;
                $display("FAIL pause_space%0d: tx_pause=%b required %b", sp[i], tx_pause, ex[i]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [9:0] v_empty, v_eof, e_sel, e_read, e_und;
        v_empty = 10'b1100111000; v_eof  = 10'b0010000000;
        e_sel   = 10'b0011111110; e_read = 10'b0011000110; e_und = 10'b0000001000;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1 reqq_empty = v_empty[c]; reqq_eof = v_eof[c];
            @(negedge clk);
            n_tests++;
            if ({sel, reqq_read, underrun} !== {(e_sel[c] ? 2'b01 : 2'b00), e_read[c], e_und[c]}) begin
                n_fail++;
                $display("FAIL underrun_c%0d: sel,read,underrun=%b required %b", c,
                         {sel, reqq_read, underrun}, {(e_sel[c] ? 2'b01 : 2'b00), e_read[c], e_und[c]});
            end
        end
    endtask

    task automatic test_ready_toggle();
        logic [8:0] v_empty, v_eof, v_rdy, e_sel, e_read;
        int         nreads;
        v_empty = 9'b100000000; v_eof  = 9'b011000000; v_rdy = 9'b110101011;
        e_sel   = 9'b011111110; e_read = 9'b010101010;
        nreads  = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1 memq_empty = v_empty[c]; memq_eof = v_eof[c]; tx_ready = v_rdy[c];
            @(negedge clk);
            if (memq_read) nreads++;
            n_tests++;
            if ({sel, memq_read, netq_read, reqq_read} !== {(e_sel[c] ? 2'b10 : 2'b00), e_read[c], 2'b00}) begin
                n_fail++;
                $display("FAIL ready_c%0d: sel,reads=%b required %b", c, {sel, memq_read, netq_read, reqq_read},
                         {(e_sel[c] ? 2'b10 : 2'b00), e_read[c], 2'b00});
            end
        end
        n_tests++;
        if (nreads !== 4) begin
            n_fail++;
            $display("FAIL ready_read_count: reads=%0d required 4", nreads);
        end
    endtask

`ifdef SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        logic [1:0] e_sel;
        logic       e_read, e_abort;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1 netq_empty = (c == 14); netq_eof = (c == 13);
            @(negedge clk);
            e_sel   = ((c >= 1 && c <= 9) || c == 12 || c == 13) ? 2'b11 : 2'b00;
            e_read  = (c >= 1 && c <= 8) || c == 12 || c == 13;
            e_abort = (c == 9);
            n_tests++;
            if ({sel, netq_read, abort} !== {e_sel, e_read, e_abort}) begin
                n_fail++;
                $display("FAIL watchdog_c%0d: sel,read,abort=%b required %b", c,
                         {sel, netq_read, abort}, {e_sel, e_read, e_abort});
            end
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        do_reset();
        @(posedge clk); #1 netq_space = 4'd3; netq_empty = 1'b0; netq_eof = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({sel, netq_read, tx_pause} !== 4'b1111) begin
            n_fail++;
            $display("FAIL pre_reset_state: sel,read,pause=%b required 1111", {sel, netq_read, tx_pause});
        end
        @(posedge clk); #3 reset = 1'b1;
        #1;
        n_tests++;
        if ({sel, memq_read, netq_read, reqq_read, tx_pause, underrun, abort} !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %b required 00000000",
                     {sel, memq_read, netq_read, reqq_read, tx_pause, underrun, abort});
        end
        @(posedge clk); #1 idle_inputs(); reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_priority_aging();
        test_single_word();
        test_pause();
        test_underrun();
        test_ready_toggle();
`ifdef SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
